// File: rtl/mem_req_arbiter.sv
// Shares one memory-controller channel between fetch (IF) and load/store (MEM).
// Ports: clk/rst/rdy; if_* fetch port; mem_* load/store port; ctrl_* controller.
module mem_req_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rdy,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    input  logic        if_flush,
    output logic        if_done,
    output logic [31:0] if_data,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [31:0] mem_addr,
    input  logic [2:0]  mem_width,
    input  logic [31:0] mem_wdata,
    output logic        mem_done,
    output logic [31:0] mem_rdata,
    output logic        ctrl_req,
    output logic        ctrl_we,
    output logic [31:0] ctrl_addr,
    output logic [1:0]  ctrl_size,
    output logic [31:0] ctrl_wdata,
    input  logic        ctrl_done,
    input  logic [31:0] ctrl_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        BUSY_IF,
        BUSY_MEM
    } state_t;

    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(STARVE_LIMIT);

    state_t           state;
    state_t           state_n;
    logic [CNT_W-1:0] cnt;
    logic             drop;
    logic             if_elig;
    logic             grant_if;
    logic             grant_mem;
    logic [1:0]       mem_size;
    logic [31:0]      load_ext;

    assign if_elig  = if_req & ~if_flush;
    // Width code 11 is not a legal RISC-V access; run it as a word.
    assign mem_size = (mem_width[1:0] == 2'b11) ? 2'b10 : mem_width[1:0];

    always_comb begin
        state_n   = state;
        grant_if  = 1'b0;
        grant_mem = 1'b0;
        unique case (state)
            IDLE: begin
                // MEM wins unless IF has already been passed over LIMIT times.
                if (mem_req && (!if_elig || cnt != LIMIT)) begin
                    grant_mem = 1'b1;
                    state_n   = BUSY_MEM;
                end else if (if_elig) begin
                    grant_if = 1'b1;
                    state_n  = BUSY_IF;
                end
            end
            BUSY_IF, BUSY_MEM: begin
                if (ctrl_done) begin
                    state_n = IDLE;
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // ctrl_size is the latched access size; mem_width[2] is held by the
    // requester until mem_done, so it is still valid at completion.
    always_comb begin
        load_ext = ctrl_rdata;
        unique case (ctrl_size)
            2'b00: load_ext = mem_width[2]
                ? {24'b0, ctrl_rdata[7:0]}
                : {{24{ctrl_rdata[7]}}, ctrl_rdata[7:0]};
            2'b01: load_ext = mem_width[2]
                ? {16'b0, ctrl_rdata[15:0]}
                : {{16{ctrl_rdata[15]}}, ctrl_rdata[15:0]};
            default: load_ext = ctrl_rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            drop       <= 1'b0;
            if_done    <= 1'b0;
            if_data    <= '0;
            mem_done   <= 1'b0;
            mem_rdata  <= '0;
            ctrl_req   <= 1'b0;
            ctrl_we    <= 1'b0;
            ctrl_addr  <= '0;
            ctrl_size  <= '0;
            ctrl_wdata <= '0;
        end else if (rdy) begin
            state    <= state_n;
            if_done  <= 1'b0;
            mem_done <= 1'b0;
            if (grant_mem) begin
                ctrl_req   <= 1'b1;
                ctrl_we    <= mem_we;
                ctrl_addr  <= mem_addr;
                ctrl_size  <= mem_size;
                ctrl_wdata <= mem_wdata;
                if (if_elig && cnt != LIMIT) begin
                    cnt <= cnt + 1'b1;
                end
            end
            if (grant_if) begin
                ctrl_req   <= 1'b1;
                ctrl_we    <= 1'b0;
                ctrl_addr  <= if_addr;
                ctrl_size  <= 2'b10;
                ctrl_wdata <= '0;
                cnt        <= '0;
            end
            if (state == BUSY_IF) begin
                if (ctrl_done) begin
                    ctrl_req <= 1'b0;
                    drop     <= 1'b0;
                    // A flush landing on the completion edge also discards.
                    if (!drop && !if_flush) begin
                        if_done <= 1'b1;
                        if_data <= ctrl_rdata;
                    end
                end else if (if_flush) begin
                    drop <= 1'b1;
                end
            end
            if (state == BUSY_MEM && ctrl_done) begin
                ctrl_req <= 1'b0;
                mem_done <= 1'b1;
                if (!ctrl_we) begin
                    mem_rdata <= load_ext;
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_req_arbiter.sv
// Directed bench for mem_req_arbiter with a completion scoreboard.
// Drives both requesters and a simple controller from one initial block.
module tb_mem_req_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy;
    logic        if_req;
    logic [31:0] if_addr;
    logic        if_flush;
    logic        if_done;
    logic [31:0] if_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [2:0]  mem_width;
    logic [31:0] mem_wdata;
    logic        mem_done;
    logic [31:0] mem_rdata;
    logic        ctrl_req;
    logic        ctrl_we;
    logic [31:0] ctrl_addr;
    logic [1:0]  ctrl_size;
    logic [31:0] ctrl_wdata;
    logic        ctrl_done;
    logic [31:0] ctrl_rdata;

    mem_req_arbiter #(.STARVE_LIMIT(4), .CNT_W(3)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
        .if_done(if_done), .if_data(if_data),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_width(mem_width), .mem_wdata(mem_wdata),
        .mem_done(mem_done), .mem_rdata(mem_rdata),
        .ctrl_req(ctrl_req), .ctrl_we(ctrl_we), .ctrl_addr(ctrl_addr),
        .ctrl_size(ctrl_size), .ctrl_wdata(ctrl_wdata),
        .ctrl_done(ctrl_done), .ctrl_rdata(ctrl_rdata)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        is_if;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    logic [2:0]  wtab[5];
    logic [1:0]  stab[5];
    logic [31:0] etab[5];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic is_if, input logic [31:0] data);
        exp_t e;
        e.is_if = is_if;
        e.data  = data;
        exp_q.push_back(e);
    endtask

    task automatic wait_grant(input string tag);
        int n = 0;
        while (ctrl_req !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_grant"}, 32'(ctrl_req), 32'd1);
    endtask

    // Controller: answer one cycle into the request, then complete.
    task automatic serve(input logic [31:0] d);
        tick();
        ctrl_done  = 1'b1;
        ctrl_rdata = d;
        tick();
        ctrl_done  = 1'b0;
        ctrl_rdata = 32'hA5A5_5A5A;
    endtask

    task automatic check_done(input string tag);
        exp_t e;
        if (exp_q.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, "_if_done"}, 32'(if_done), 32'(e.is_if));
        chk({tag, "_mem_done"}, 32'(mem_done), 32'(!e.is_if));
        chk({tag, "_data"}, e.is_if ? if_data : mem_rdata, e.data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        wtab = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010};
        stab = '{2'b00, 2'b00, 2'b01, 2'b01, 2'b10};
        etab = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_8080,
                 32'h0000_8080, 32'hDEAD_8080};
        rst = 1'b1; rdy = 1'b1;
        if_req = 0; if_addr = 0; if_flush = 0;
        mem_req = 0; mem_we = 0; mem_addr = 0; mem_width = 0; mem_wdata = 0;
        ctrl_done = 0; ctrl_rdata = 0;
        tick();
        tick();
        chk("rst_ctrl_req", 32'(ctrl_req), 32'd0);
        chk("rst_if_done", 32'(if_done), 32'd0);
        chk("rst_mem_done", 32'(mem_done), 32'd0);
        chk("rst_ctrl_addr", ctrl_addr, 32'd0);
        chk("rst_if_data", if_data, 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        rst = 1'b0;
        tick();

        // IF only
        if_req = 1; if_addr = 32'h100;
        push(1'b1, 32'h00A0_0093);
        tick();
        chk("ifonly_req", 32'(ctrl_req), 32'd1);
        chk("ifonly_addr", ctrl_addr, 32'h100);
        chk("ifonly_size", 32'(ctrl_size), 32'd2);
        chk("ifonly_we", 32'(ctrl_we), 32'd0);
        serve(32'h00A0_0093);
        check_done("ifonly");
        if_req = 0;
        tick();
        chk("ifonly_pulse", 32'(if_done), 32'd0);
        chk("ifonly_idle", 32'(ctrl_req), 32'd0);

        // Simultaneous: MEM first, then IF
        mem_req = 1; mem_we = 0; mem_addr = 32'h200; mem_width = 3'b000;
        if_req = 1; if_addr = 32'h104;
        push(1'b0, 32'hFFFF_FFF0);
        push(1'b1, 32'h1111_1111);
        tick();
        chk("sim_first", ctrl_addr, 32'h200);
        serve(32'h0000_00F0);
        check_done("sim_mem");
        mem_req = 0;
        tick();
        chk("sim_second", ctrl_addr, 32'h104);
        serve(32'h1111_1111);
        check_done("sim_if");
        if_req = 0;
        tick();

        // Load extension
        for (int i = 0; i < 5; i++) begin
            mem_req = 1; mem_addr = 32'h240; mem_width = wtab[i];
            push(1'b0, etab[i]);
            wait_grant("ext");
            chk("ext_size", 32'(ctrl_size), 32'(stab[i]));
            serve(32'hDEAD_8080);
            check_done("ext");
            mem_req = 0;
            tick();
        end

        // Store leaves mem_rdata alone
        mem_req = 1; mem_we = 1; mem_addr = 32'h244;
        mem_width = 3'b010; mem_wdata = 32'hCAFE_BABE;
        push(1'b0, 32'hDEAD_8080);
        wait_grant("st");
        chk("st_we", 32'(ctrl_we), 32'd1);
        chk("st_wdata", ctrl_wdata, 32'hCAFE_BABE);
        chk("st_addr", ctrl_addr, 32'h244);
        serve(32'h1234_5678);
        check_done("st");
        mem_req = 0; mem_we = 0;
        tick();

        // Starvation: 4 MEM, 1 IF, then again from zero
        if_req = 1; if_addr = 32'h300;
        mem_req = 1; mem_addr = 32'h400; mem_width = 3'b010;
        for (int g = 0; g < 10; g++) begin
            logic is_if;
            is_if = (g == 4 || g == 9);
            push(is_if, 32'h5000_0000 + 32'(g));
            wait_grant("starve");
            chk("starve_order", ctrl_addr, is_if ? 32'h300 : 32'h400);
            serve(32'h5000_0000 + 32'(g));
            check_done("starve");
        end
        if_req = 0; mem_req = 0;
        tick();

        // Flush while busy on IF
        if_req = 1; if_addr = 32'h500;
        wait_grant("flush");
        chk("flush_addr", ctrl_addr, 32'h500);
        if_flush = 1; if_req = 0;
        tick();
        if_flush = 0;
        ctrl_done = 1; ctrl_rdata = 32'hBADB_AD00;
        tick();
        ctrl_done = 0;
        chk("flush_no_done", 32'(if_done), 32'd0);
        chk("flush_data_held", if_data, 32'h5000_0009);
        chk("flush_idle", 32'(ctrl_req), 32'd0);
        tick();
        chk("flush_no_late", 32'(if_done), 32'd0);
        if_req = 1; if_addr = 32'h504;
        push(1'b1, 32'h0000_0013);
        wait_grant("after_flush");
        chk("after_flush_addr", ctrl_addr, 32'h504);
        serve(32'h0000_0013);
        check_done("after_flush");
        if_req = 0;
        tick();

        // Flush in IDLE blocks that cycle only
        if_req = 1; if_addr = 32'h508; if_flush = 1;
        push(1'b1, 32'h0000_0033);
        tick();
        chk("idle_flush_block", 32'(ctrl_req), 32'd0);
        if_flush = 0;
        tick();
        chk("idle_flush_grant", 32'(ctrl_req), 32'd1);
        serve(32'h0000_0033);
        check_done("idle_flush");
        if_req = 0;
        tick();

        // Stall holds the done pulse and the FSM
        mem_req = 1; mem_addr = 32'h600; mem_width = 3'b010;
        push(1'b0, 32'h600D_DA7A);
        wait_grant("stall");
        serve(32'h600D_DA7A);
        check_done("stall");
        rdy = 0;
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("stall_done_held", 32'(mem_done), 32'd1);
            chk("stall_no_grant", 32'(ctrl_req), 32'd0);
        end
        rdy = 1;
        tick();
        chk("stall_release", 32'(mem_done), 32'd0);
        chk("stall_regrant", 32'(ctrl_req), 32'd1);

        // Reset in BUSY_MEM aborts without a done pulse
        rst = 1; ctrl_done = 1; ctrl_rdata = 32'h7777_7777;
        tick();
        rst = 0; ctrl_done = 0; mem_req = 0;
        chk("rst_busy_req", 32'(ctrl_req), 32'd0);
        chk("rst_busy_done", 32'(mem_done), 32'd0);
        chk("rst_busy_rdata", mem_rdata, 32'd0);
        tick();
        chk("rst_busy_after", 32'(mem_done), 32'd0);
        mem_req = 1; mem_addr = 32'h604;
        push(1'b0, 32'h0604_0604);
        tick();
        chk("rst_idle_grant", 32'(ctrl_req), 32'd1);
        chk("rst_idle_addr", ctrl_addr, 32'h604);
        serve(32'h0604_0604);
        check_done("post_rst");
        mem_req = 0;
        tick();

        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
